// File: rtl/timer_irq.sv
// timer_irq: memory-mapped countdown timer that raises an interrupt request for CP0 HWInt.
// It supports one-shot mode with a sticky interrupt and auto-reload mode with a one-cycle pulse.
// The optional prescaler is enabled by defining TIMER_IRQ_PRESCALE_EN.
module timer_irq #(
  parameter logic [1:0] CTRL_ADDR   = 2'd0,
  parameter logic [1:0] PRESET_ADDR = 2'd1,
  parameter logic [1:0] COUNT_ADDR  = 2'd2,
  parameter logic [1:0] STAT_ADDR   = 2'd3
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } stateT;

  stateT       state, stateNext;
  logic        en, enNext;
  logic [1:0]  mode, modeNext;
  logic        im, imNext;
  logic [31:0] preset, presetNext;
  logic [31:0] count, countNext;
  logic        flag, flagNext;
  logic        irq;
  logic        ctrlWr, presetWr;
  logic        tick;
  logic [7:0]  psView;

`ifdef TIMER_IRQ_PRESCALE_EN
  logic [7:0]  ps, psNext;
  logic [7:0]  psCnt, psCntNext;

  assign psView = ps;
`else
  assign psView = 8'd0;
`endif

  // Next-state logic: the FSM step first, then software writes override any same-edge hardware update.
  always_comb begin
    ctrlWr     = WE && (Addr == CTRL_ADDR);
    presetWr   = WE && (Addr == PRESET_ADDR);
    enNext     = ctrlWr ? DIn[0]   : en;
    modeNext   = ctrlWr ? DIn[2:1] : mode;
    imNext     = ctrlWr ? DIn[3]   : im;
    presetNext = presetWr ? DIn    : preset;
    countNext  = count;
    flagNext   = flag;
    stateNext  = state;
`ifdef TIMER_IRQ_PRESCALE_EN
    psNext     = ctrlWr ? DIn[15:8] : ps;
    psCntNext  = psCnt;
    tick       = (psCnt == ps);
`else
    tick       = 1'b1;
`endif
    case (state)
      IDLE: begin
        if (enNext) stateNext = LOAD;
      end
      LOAD: begin
        countNext = preset;
`ifdef TIMER_IRQ_PRESCALE_EN
        psCntNext = 8'd0;
`endif
        stateNext = CNT;
      end
      CNT: begin
        if (!enNext) begin
          stateNext = IDLE;
`ifdef TIMER_IRQ_PRESCALE_EN
          psCntNext = 8'd0;
`endif
        end else if (tick) begin
`ifdef TIMER_IRQ_PRESCALE_EN
          psCntNext = 8'd0;
`endif
          if (count <= 32'd1) begin
            countNext = 32'd0;
            flagNext  = 1'b1;
            stateNext = INT;
          end else begin
            countNext = count - 32'd1;
          end
        end else begin
`ifdef TIMER_IRQ_PRESCALE_EN
          psCntNext = psCnt + 8'd1;
`endif
        end
      end
      INT: begin
        if (mode == 2'b01) begin
          flagNext  = 1'b0;
          stateNext = LOAD;
        end else begin
          if (!ctrlWr) enNext = 1'b0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (ctrlWr || presetWr) flagNext = 1'b0;
  end

  // State and register update; IRQ is registered from the next flag and mask values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      en     <= 1'b0;
      mode   <= 2'b00;
      im     <= 1'b0;
      preset <= 32'd0;
      count  <= 32'd0;
      flag   <= 1'b0;
      irq    <= 1'b0;
`ifdef TIMER_IRQ_PRESCALE_EN
      ps     <= 8'd0;
      psCnt  <= 8'd0;
`endif
    end else begin
      state  <= stateNext;
      en     <= enNext;
      mode   <= modeNext;
      im     <= imNext;
      preset <= presetNext;
      count  <= countNext;
      flag   <= flagNext;
      irq    <= flagNext & imNext;
`ifdef TIMER_IRQ_PRESCALE_EN
      ps     <= psNext;
      psCnt  <= psCntNext;
`endif
    end
  end

  // Combinational read mux over the four registers.
  always_comb begin
    DOut = 32'd0;
    case (Addr)
      CTRL_ADDR:   DOut = {16'd0, psView, 4'd0, im, mode, en};
      PRESET_ADDR: DOut = preset;
      COUNT_ADDR:  DOut = count;
      STAT_ADDR:   DOut = {31'd0, flag};
      default:     DOut = 32'd0;
    endcase
  end

  assign IRQ = irq;

endmodule
